// File: rtl/arbiter_n_to_1_request_pkg.sv
// Shared packet and FIFO-state types for the N-to-1 request arbiter,
// plus the grant FSM state enum.
package arbiter_n_to_1_request_pkg;

  localparam int ROUTE_W         = 8;
  localparam int DATA_W          = 32;
  localparam int RST_BUSY_CYCLES = 4;

  typedef struct packed {
    logic [ROUTE_W-1:0] src;
    logic [ROUTE_W-1:0] to;
  } MemoryPacketRoute;

  typedef struct packed {
    MemoryPacketRoute route;
    logic [3:0]       cmd;
  } MemoryPacketMeta;

  typedef struct packed {
    logic [DATA_W-1:0] field;
  } MemoryPacketData;

  typedef struct packed {
    MemoryPacketMeta meta;
    MemoryPacketData data;
  } MemoryPacketPayload;

  typedef struct packed {
    logic               valid;
    MemoryPacketPayload payload;
  } MemoryPacket;

  typedef struct packed {
    logic rd_en;
  } FIFOStateSignalsInput;

  typedef struct packed {
    logic valid;
    logic empty;
    logic full;
    logic prog_full;
    logic rst_busy;
  } FIFOStateSignalsOutput;

  typedef struct packed {
    logic rd_en;
    logic wr_en;
  } FIFOStateSignalsInputInternal;

  typedef struct packed {
    logic valid;
    logic empty;
    logic full;
    logic prog_full;
    logic wr_rst_busy;
    logic rd_rst_busy;
  } FIFOStateSignalsOutputInternal;

  typedef enum logic [1:0] {
    RESET,
    SETUP,
    ARBITRATE,
    STALL
  } arbiter_N_to_1_state_t;

  function automatic FIFOStateSignalsOutput map_internal_fifo_signals_to_output(
    input FIFOStateSignalsOutputInternal s
  );
    FIFOStateSignalsOutput o;
    o.valid     = s.valid;
    o.empty     = s.empty;
    o.full      = s.full;
    o.prog_full = s.prog_full;
    o.rst_busy  = s.wr_rst_busy | s.rd_rst_busy;
    return o;
  endfunction

endpackage

// File: rtl/round_robin_priority_arbiter_N_input.sv
// Round-robin grant: first requester at or after last_grant+1 (mod N) wins.
module round_robin_priority_arbiter_N_input #(
  parameter int N = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_last_grant,
  output logic [N-1:0] o_grant,
  output logic         o_valid
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] w_base;
  logic [IW-1:0] w_idx;

  always_comb begin
    w_base  = '0;
    w_idx   = '0;
    o_grant = '0;
    o_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (i_last_grant[j]) w_base = IW'(j);
    end
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(w_base) + k) % N);
      if (!o_valid && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xpm_fifo_sync_wrapper.sv
// Synchronous first-word-fall-through FIFO with a post-reset busy window
// during which reads and writes are ignored.
module xpm_fifo_sync_wrapper
  import arbiter_n_to_1_request_pkg::*;
#(
  parameter int FIFO_WRITE_DEPTH = 32,
  parameter int PROG_THRESH      = 16,
  parameter int WIDTH            = 8
) (
  input  logic                          i_clk,
  input  logic                          i_srst,
  input  logic [WIDTH-1:0]              i_din,
  input  FIFOStateSignalsInputInternal  i_fifo_in,
  output logic [WIDTH-1:0]              o_dout,
  output FIFOStateSignalsOutputInternal o_fifo_out
);

  localparam int AW = $clog2(FIFO_WRITE_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(RST_BUSY_CYCLES + 1);

  logic [WIDTH-1:0] r_mem [FIFO_WRITE_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [BW-1:0]    r_busy_cnt;

  logic w_busy;
  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;

  assign w_busy  = i_srst | (r_busy_cnt != '0);
  assign w_full  = (r_count == CW'(FIFO_WRITE_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_wr    = i_fifo_in.wr_en & ~w_full & ~w_busy;
  assign w_rd    = i_fifo_in.rd_en & ~w_empty & ~w_busy;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_busy_cnt <= BW'(RST_BUSY_CYCLES);
    end else begin
      if (r_busy_cnt != '0) r_busy_cnt <= r_busy_cnt - 1'b1;
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout                 = r_mem[r_rd_ptr];
  assign o_fifo_out.valid       = ~w_empty & ~w_busy;
  assign o_fifo_out.empty       = w_empty;
  assign o_fifo_out.full        = w_full;
  assign o_fifo_out.prog_full   = (r_count >= CW'(PROG_THRESH));
  assign o_fifo_out.wr_rst_busy = w_busy;
  assign o_fifo_out.rd_rst_busy = w_busy;

endmodule

// File: rtl/arbiter_n_to_1_request.sv
// Round-robin N-to-1 MemoryPacket arbiter with per-requester FWFT ingress
// FIFOs and a two-stage registered output.
//
//  state     | meaning
//  ----------+---------------------------------------------
//  RESET     | registered reset active
//  SETUP     | waiting for every ingress FIFO to leave reset-busy
//  ARBITRATE | one pop per cycle allowed
//  STALL     | downstream not accepting, no pops
module arbiter_n_to_1_request
  import arbiter_n_to_1_request_pkg::*;
#(
  parameter int NUM_MEMORY_REQUESTOR = 2,
  parameter int FIFO_ARBITER_DEPTH   = 16,
  parameter int FIFO_WRITE_DEPTH     = 2**$clog2(FIFO_ARBITER_DEPTH + 16),
  parameter int PROG_THRESH          = 2**$clog2(FIFO_ARBITER_DEPTH)
) (
  input  logic                  ap_clk,
  input  logic                  areset_n,
  input  MemoryPacket           request_in [NUM_MEMORY_REQUESTOR-1:0],
  input  FIFOStateSignalsInput  fifo_request_signals_in,
  output FIFOStateSignalsOutput fifo_request_signals_out [NUM_MEMORY_REQUESTOR-1:0],
  output MemoryPacket           request_out,
  output logic [NUM_MEMORY_REQUESTOR-1:0] grant_out,
  output logic                  fifo_setup_signal
);

  localparam int N  = NUM_MEMORY_REQUESTOR;
  localparam int PW = $bits(MemoryPacketPayload);

  logic r_ctrl_rst_n;
  logic r_fifo_rst_n;
  logic r_rd_en;

  logic [N-1:0]       r_req_valid;
  MemoryPacketPayload r_req_payload [N];
  FIFOStateSignalsOutput r_fifo_state [N];

  FIFOStateSignalsInputInternal  w_fifo_in  [N];
  FIFOStateSignalsOutputInternal w_fifo_out [N];
  MemoryPacketPayload            w_dout     [N];

  logic [N-1:0] w_req;
  logic [N-1:0] w_busy;
  logic [N-1:0] w_grant;
  logic         w_grant_valid;
  logic [N-1:0] w_pop;
  logic [N-1:0] r_last_grant;
  logic         w_fifo_srst;

  arbiter_N_to_1_state_t r_state;
  arbiter_N_to_1_state_t w_next_state;

  MemoryPacketPayload w_pop_payload;
  MemoryPacketPayload r_dout_payload;
  MemoryPacketPayload r_out_payload;
  logic               r_dout_valid;
  logic               r_out_valid;
  logic [N-1:0]       r_dout_grant;
  logic [N-1:0]       r_out_grant;
  logic               r_setup;

  // The reset input is itself the source of the synchronous resets below.
  always_ff @(posedge ap_clk) begin
    r_ctrl_rst_n <= areset_n;
    r_fifo_rst_n <= areset_n;
  end

  assign w_fifo_srst = ~r_fifo_rst_n;

  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < N; i++) begin
      r_req_payload[i] <= request_in[i].payload;
      r_fifo_state[i]  <= map_internal_fifo_signals_to_output(w_fifo_out[i]);
    end
    if (!r_ctrl_rst_n) begin
      r_req_valid <= '0;
      r_rd_en     <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) r_req_valid[i] <= request_in[i].valid;
      r_rd_en <= fifo_request_signals_in.rd_en;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_req
    // Packets with no destination are dropped at the FIFO write port.
    assign w_fifo_in[i].wr_en = r_req_valid[i] & (|r_req_payload[i].meta.route.to);
    assign w_fifo_in[i].rd_en = w_pop[i];

    xpm_fifo_sync_wrapper #(
      .FIFO_WRITE_DEPTH (FIFO_WRITE_DEPTH),
      .PROG_THRESH      (PROG_THRESH),
      .WIDTH            (PW)
    ) u_fifo (
      .i_clk      (ap_clk),
      .i_srst     (w_fifo_srst),
      .i_din      (r_req_payload[i]),
      .i_fifo_in  (w_fifo_in[i]),
      .o_dout     (w_dout[i]),
      .o_fifo_out (w_fifo_out[i])
    );

    assign w_req[i]  = w_fifo_out[i].valid & ~w_fifo_out[i].empty;
    assign w_busy[i] = w_fifo_out[i].wr_rst_busy | w_fifo_out[i].rd_rst_busy;
    assign fifo_request_signals_out[i] = r_fifo_state[i];
  end

  round_robin_priority_arbiter_N_input #(.N(N)) u_rr (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_valid      (w_grant_valid)
  );

  always_ff @(posedge ap_clk) begin
    if (!r_ctrl_rst_n) r_state <= RESET;
    else               r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RESET:     w_next_state = SETUP;
      SETUP:     if (!(|w_busy)) w_next_state = ARBITRATE;
      ARBITRATE: if (!r_rd_en)   w_next_state = STALL;
      STALL:     if (r_rd_en)    w_next_state = ARBITRATE;
      default:   w_next_state = RESET;
    endcase
  end

  always_comb begin
    w_pop = '0;
    if (r_state == ARBITRATE && w_grant_valid) w_pop = w_grant;
  end

  always_comb begin
    w_pop_payload = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pop[i]) w_pop_payload = w_pop_payload | w_dout[i];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!r_ctrl_rst_n) begin
      r_last_grant <= {1'b1, {(N-1){1'b0}}};
      r_dout_valid <= 1'b0;
      r_dout_grant <= '0;
      r_out_valid  <= 1'b0;
      r_out_grant  <= '0;
      r_setup      <= 1'b1;
    end else begin
      if (|w_pop) r_last_grant <= w_pop;
      r_dout_valid <= |w_pop;
      r_dout_grant <= w_pop;
      r_out_valid  <= r_dout_valid;
      r_out_grant  <= r_dout_grant;
      r_setup      <= |w_busy;
    end
  end

  always_ff @(posedge ap_clk) begin
    r_dout_payload <= w_pop_payload;
    r_out_payload  <= r_dout_payload;
  end

  assign request_out.valid   = r_out_valid;
  assign request_out.payload = r_out_payload;
  assign grant_out           = r_out_grant;
  assign fifo_setup_signal   = r_setup;

endmodule

// File: doc/arbiter_n_to_1_request.md
# arbiter_N_to_1_request

Round-robin N-to-1 request arbiter that merges `MemoryPacket` streams from `NUM_MEMORY_REQUESTOR` requesters onto one downstream port. Each requester has its own FWFT ingress FIFO. A grant FSM pops one packet per cycle while the downstream consumer asserts `rd_en`. It sits upstream of the shared memory/cache channel and is the converging counterpart of the per-bundle request demux.

## Interface
- `NUM_MEMORY_REQUESTOR`, 2: number of requesters N (≥2).
- `FIFO_ARBITER_DEPTH`, 16: nominal per-requester buffering.
- `FIFO_WRITE_DEPTH`, 2**$clog2(FIFO_ARBITER_DEPTH+16): physical depth of each ingress FIFO.
- `PROG_THRESH`, 2**$clog2(FIFO_ARBITER_DEPTH): `prog_full` threshold per ingress FIFO.
- `ap_clk`  in  1  clock; all logic is on the rising edge.
- `areset_n`  in  1  reset; one clock, synchronous, active-low. It is registered once internally into separate control and FIFO reset copies.
- `request_in[N-1:0]`  in  N×MemoryPacket  per-requester packet, qualified by `.valid`.
- `fifo_request_signals_in`  in  FIFOStateSignalsInput  downstream consumer; `.rd_en`=1 means it accepts a packet.
- `fifo_request_signals_out[N-1:0]`  out  N×FIFOStateSignalsOutput  registered ingress FIFO state per requester, used by upstream for backpressure.
- `request_out`  out  MemoryPacket  arbitrated packet.
- `grant_out`  out  N  one-hot index of the requester whose packet is on `request_out`.
- `fifo_setup_signal`  out  1  high while any ingress FIFO is in reset.

## Operation
- **Ingress:**
  - `request_in[i]` is registered once.
  - The FIFO write enable is `valid & |payload.meta.route.to`; packets with an all-zero route are dropped silently.
- **Pop qualifier:** `fifo_request_signals_in.rd_en` is registered once as `rd_en_reg`.
- **FSM states:**
  - RESET: entered while the registered reset is active.
  - SETUP: held while any FIFO reports `wr_rst_busy|rd_rst_busy`.
  - ARBITRATE: pops are allowed.
  - STALL: no pops.
- **FSM transitions:**
  - RESET→SETUP on reset release.
  - SETUP→ARBITRATE when every FIFO reports not busy.
  - ARBITRATE→STALL when `rd_en_reg`=0.
  - STALL→ARBITRATE when `rd_en_reg`=1.
  - Any state→RESET on reset.
- **Grant:**
  - Grants are issued only in ARBITRATE.
  - `req[i] = fifo[i].valid & ~fifo[i].empty`.
  - The grant goes to the first `i` with `req[i]=1`, searching from `last_grant+1` modulo N.
  - The granted FIFO's `rd_en` is pulsed for exactly that cycle, so at most one pop per cycle.
  - `last_grant` updates only when a grant is issued.
- **Output:**
  - The popped payload and one-hot grant are registered twice (dout reg, output reg).
  - `request_out.valid`=1 only for a popped packet.
  - Payload registers have no reset.
- **Fairness:** with all N requesters continuously non-empty and `rd_en`=1, grants cycle 0,1,…,N-1,0,…; no requester waits more than N-1 grants.
- **Full condition:**
  - Upstream must stop writing on `prog_full`.
  - A write into a full FIFO is discarded by the FIFO; the arbiter does not add recovery.
- **Simultaneous events:** a write and a pop on the same FIFO in the same cycle are both legal.
- **Reset mid-operation:** in-flight output registers are invalidated and FIFO contents are flushed.

## Timing
- **Reset values:**
  - `request_out.valid`=0.
  - `grant_out`=0.
  - `fifo_setup_signal`=1.
  - `last_grant`=N-1, so requester 0 wins the first grant.
  - `fifo_request_signals_out[i]` takes the FIFO's own reset-state values one cycle later.
- **Latency:**
  - Pop at cycle c gives `request_out.valid` at c+2.
  - The `rd_en` input at cycle t allows pops from t+1.
  - End-to-end latency is 1 (input reg) + FIFO FWFT write-to-valid + 2.
- **Overshoot:** after downstream drops `rd_en`, at most 3 further packets may appear (1 from the pop at the rd_en-register cycle, 2 in the pipeline). Downstream must absorb 3 packets beyond its deassertion point.
- **`fifo_setup_signal`:** is `|rst_busy` registered one cycle.

## Structure
- **Shared package (`global_package`):** `MemoryPacket`, `MemoryPacketPayload`, `FIFOStateSignalsInput/Output`, the `Internal` variants and `map_internal_fifo_signals_to_output`. The FSM state enum `arbiter_N_to_1_state_t` is added there.
- **Sub-modules:**
  - N instances of `xpm_fifo_sync_wrapper` (FWFT), generated by loop.
  - Round-robin grant logic as one sub-module, `round_robin_priority_arbiter_N_input`: inputs `req[N]` and `last_grant[N]`, outputs one-hot `grant` and `valid`.

## Test plan
- **Reset/setup:** hold `areset_n`=0 for 5 cycles, then release → `fifo_setup_signal`=1 until all FIFOs are not busy, then 0; no `request_out.valid` during this time.
- **Single requester:** requester 1 of N=4 sends 3 packets with `route.to`=1 and `rd_en`=1 → 3 packets in order, `grant_out`=4'b0010, payloads match.
- **Fairness:** all 4 requesters preloaded with 4 packets each, `rd_en`=1 → 16 outputs with `grant_out` sequence 0,1,2,3 repeated 4 times.
- **Backpressure:** `rd_en` dropped at cycle t for 10 cycles → no more than 3 valids after t; the remaining packets resume after re-assertion with none lost or duplicated.
- **Drop and full:** a packet with `route.to`=0 → never output. Fill requester 0 to `PROG_THRESH` → `fifo_request_signals_out[0].prog_full`=1 within 2 cycles.
- **Mid-stream reset:** assert reset during a burst → `request_out.valid`=0 on the next registered cycle; after setup, FIFOs are empty and arbitration restarts at requester 0.
